brief_desc_packer: RTL and testbench

BRIEF_DESC_PACKER -- requirements
Module: brief_desc_packer

---
 rtl/brief_desc_packer_pkg.sv | 11 +
 rtl/brief_desc_packer.sv | 164 ++++++++++++++++
 tb/tb_brief_desc_packer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/brief_desc_packer_pkg.sv
// Shared ORB BRIEF definitions: packer state encoding and default descriptor length.
package brief_desc_packer_pkg;

  localparam int DEFAULT_DESC_BITS = 256;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } pack_state_t;

endpackage

// File: rtl/brief_desc_packer.sv
// Packs the serial BRIEF comparison stream into DESC_BITS-wide descriptors,
// double-buffered so a new descriptor can collect while the last one waits downstream.
module brief_desc_packer
  import brief_desc_packer_pkg::*;
#(
  parameter int DESC_BITS = DEFAULT_DESC_BITS,
  parameter int CNT_W     = $clog2(DESC_BITS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_data,
  input  logic                 i_sof,
  input  logic                 i_ready,
  input  logic                 i_clr_err,
  output logic [DESC_BITS-1:0] o_desc,
  output logic                 o_valid,
  output logic [CNT_W-1:0]     o_bit_cnt,
  output logic                 o_overflow,
  output logic                 o_sync_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DESC_BITS - 1);

  pack_state_t          state;
  pack_state_t          next_state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     wr_idx;
  logic [DESC_BITS-1:0] acc;
  logic [DESC_BITS-1:0] acc_wr;
  logic [DESC_BITS-1:0] desc_reg;
  logic                 valid_reg;
  logic                 overflow_reg;
  logic                 sync_err_reg;

  logic handshake;
  logic slot_free;
  logic take_bit;
  logic sof_bit;
  logic complete;
  logic load_direct;
  logic drain;
  logic drop_bit;
  logic sync_set;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // A finished descriptor parks in the accumulator only when the output slot is still occupied.
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: begin
        if (complete && !slot_free) begin
          next_state = PENDING;
        end
      end
      PENDING: begin
        if (handshake) begin
          next_state = COLLECT;
        end
      end
      default: next_state = COLLECT;
    endcase
  end

  always_comb begin
    handshake   = valid_reg && i_ready;
    slot_free   = !valid_reg || i_ready;
    take_bit    = 1'b0;
    sof_bit     = 1'b0;
    complete    = 1'b0;
    drain       = 1'b0;
    drop_bit    = 1'b0;
    case (state)
      COLLECT: begin
        take_bit = i_en;
        sof_bit  = i_en && i_sof;
        complete = i_en && !i_sof && (bit_cnt == LAST_IDX);
      end
      PENDING: begin
        drain    = handshake;
        drop_bit = i_en;
      end
      default: begin
        take_bit = 1'b0;
      end
    endcase
    load_direct = complete && slot_free;
    sync_set    = sof_bit && (bit_cnt != '0);
    wr_idx      = sof_bit ? '0 : bit_cnt;
  end

  always_comb begin
    acc_wr         = acc;
    acc_wr[wr_idx] = i_data;
  end

  // A start-of-frame bit restarts collection at index 0, discarding any partial bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (take_bit) begin
      acc <= acc_wr;
      if (sof_bit) begin
        bit_cnt <= CNT_W'(1);
      end else if (complete) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      desc_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (load_direct) begin
        desc_reg <= acc_wr;
      end else if (drain) begin
        desc_reg <= acc;
      end
      if (load_direct || drain) begin
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Set events take priority over a clear arriving in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_reg <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      if (drop_bit) begin
        overflow_reg <= 1'b1;
      end else if (i_clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (sync_set) begin
        sync_err_reg <= 1'b1;
      end else if (i_clr_err) begin
        sync_err_reg <= 1'b0;
      end
    end
  end

  assign o_desc     = desc_reg;
  assign o_valid    = valid_reg;
  assign o_bit_cnt  = bit_cnt;
  assign o_overflow = overflow_reg;
  assign o_sync_err = sync_err_reg;

endmodule

// File: tb/tb_brief_desc_packer.sv
// Self-checking bench: directed cases on an 8-bit packer, scoreboarded random stream on a 256-bit packer.
module tb_brief_desc_packer;

  localparam int SB = 8;
  localparam int LB = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_en, a_data, a_sof, a_ready, a_clr;
  logic [SB-1:0] a_desc;
  logic          a_valid, a_ovf, a_serr;
  logic [2:0]    a_cnt;

  logic          b_en, b_data, b_sof, b_ready, b_clr;
  logic [LB-1:0] b_desc;
  logic          b_valid, b_ovf, b_serr;
  logic [7:0]    b_cnt;

  brief_desc_packer #(.DESC_BITS(SB)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_en(a_en), .i_data(a_data), .i_sof(a_sof),
    .i_ready(a_ready), .i_clr_err(a_clr), .o_desc(a_desc), .o_valid(a_valid),
    .o_bit_cnt(a_cnt), .o_overflow(a_ovf), .o_sync_err(a_serr)
  );

  brief_desc_packer #(.DESC_BITS(LB)) dut_large (
    .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_data(b_data), .i_sof(b_sof),
    .i_ready(b_ready), .i_clr_err(b_clr), .o_desc(b_desc), .o_valid(b_valid),
    .o_bit_cnt(b_cnt), .o_overflow(b_ovf), .o_sync_err(b_serr)
  );

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  logic [LB-1:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [LB-1:0] observed,
                             input logic [LB-1:0] expected);
    compare_cnt++;
    if (observed !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic popCompare(input string tag, input logic [LB-1:0] observed);
    checkOutput({tag, "_avail"}, LB'(exp_q.size() != 0), LB'(1));
    if (exp_q.size() != 0) begin
      checkOutput(tag, observed, exp_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic en, input logic data, input logic sof,
                               input logic ready, input logic clr);
    a_en    = en;
    a_data  = data;
    a_sof   = sof;
    a_ready = ready;
    a_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [7:0] d, input int lo, input int hi,
                          input logic sof_lo, input logic ready);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(1'b1, d[i], sof_lo && (i == lo), ready, 1'b0);
    end
  endtask

  logic [LB-1:0] m_acc;
  int            m_cnt;
  logic          m_valid, m_pend, m_ovf, m_loaded;
  logic          r_en, r_data, r_rdy;

  initial begin
    rst = 1'b1;
    a_en = 0; a_data = 0; a_sof = 0; a_ready = 0; a_clr = 0;
    b_en = 0; b_data = 0; b_sof = 0; b_ready = 0; b_clr = 0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_valid", a_valid, 0);
    checkOutput("rst_desc", a_desc, 0);
    checkOutput("rst_cnt", a_cnt, 0);
    checkOutput("rst_ovf", a_ovf, 0);
    checkOutput("rst_serr", a_serr, 0);
    rst = 1'b0;

    // Basic pack, one-cycle latency
    exp_q.push_back(LB'(8'h4D));
    sendBits(8'h4D, 0, 6, 1'b1, 1'b1);
    checkOutput("t1_valid_early", a_valid, 0);
    checkOutput("t1_cnt7", a_cnt, 7);
    sendBits(8'h4D, 7, 7, 1'b0, 1'b1);
    checkOutput("t1_valid", a_valid, 1);
    checkOutput("t1_cnt_wrap", a_cnt, 0);
    popCompare("t1_desc", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1_consumed", a_valid, 0);

    // Back-to-back with downstream stalled: PENDING then overflow
    exp_q.push_back(LB'(8'hA5));
    exp_q.push_back(LB'(8'h3C));
    sendBits(8'hA5, 0, 7, 1'b1, 1'b0);
    checkOutput("t2_valid1", a_valid, 1);
    sendBits(8'h3C, 0, 7, 1'b1, 1'b0);
    checkOutput("t2_ovf_none", a_ovf, 0);
    checkOutput("t2_cnt", a_cnt, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t2_ovf_set", a_ovf, 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("t2_sof_dropped", a_serr, 0);
    checkOutput("t2_cnt_hold", a_cnt, 0);
    popCompare("t2_first", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_valid_stays", a_valid, 1);
    popCompare("t2_second", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t2_consumed", a_valid, 0);
    checkOutput("t2_ovf_clr", a_ovf, 0);

    // Completion on the handshake edge
    exp_q.push_back(LB'(8'h96));
    exp_q.push_back(LB'(8'h5A));
    sendBits(8'h96, 0, 7, 1'b1, 1'b0);
    sendBits(8'h5A, 0, 6, 1'b1, 1'b0);
    popCompare("t3_first", LB'(a_desc));
    sendBits(8'h5A, 7, 7, 1'b0, 1'b1);
    checkOutput("t3_valid", a_valid, 1);
    checkOutput("t3_ovf", a_ovf, 0);
    popCompare("t3_second", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t3_consumed", a_valid, 0);

    // Early start-of-frame resynchronises
    exp_q.push_back(LB'(8'hC3));
    sendBits(8'h05, 0, 2, 1'b1, 1'b1);
    checkOutput("t4_cnt3", a_cnt, 3);
    sendBits(8'hC3, 0, 0, 1'b1, 1'b1);
    checkOutput("t4_serr", a_serr, 1);
    checkOutput("t4_cnt1", a_cnt, 1);
    sendBits(8'hC3, 1, 7, 1'b0, 1'b1);
    checkOutput("t4_valid", a_valid, 1);
    popCompare("t4_desc", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t4_serr_clr", a_serr, 0);

    // Asynchronous reset mid-descriptor
    sendBits(8'hE7, 0, 7, 1'b1, 1'b0);
    sendBits(8'h2B, 0, 4, 1'b1, 1'b0);
    checkOutput("t5_cnt5", a_cnt, 5);
    checkOutput("t5_valid_pre", a_valid, 1);
    a_en = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_valid", a_valid, 0);
    checkOutput("t5_desc", a_desc, 0);
    checkOutput("t5_cnt", a_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(LB'(8'h71));
    sendBits(8'h71, 0, 6, 1'b1, 1'b1);
    checkOutput("t5_no_early", a_valid, 0);
    sendBits(8'h71, 7, 7, 1'b0, 1'b1);
    checkOutput("t5_valid_new", a_valid, 1);
    popCompare("t5_desc_new", LB'(a_desc));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("dir_queue_empty", LB'(exp_q.size()), 0);

    // Random 256-bit stream; a reference packer predicts every completed descriptor
    m_acc = '0; m_cnt = 0; m_valid = 0; m_pend = 0; m_ovf = 0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      if (cyc >= 3150) begin
        r_en  = 1'b0;
        r_rdy = 1'b1;
      end else begin
        r_en  = ($urandom_range(0, 9) < 8);
        r_rdy = (((cyc / 400) % 2) == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      r_data  = 1'($urandom_range(0, 1));
      b_en    = r_en;
      b_data  = r_data;
      b_sof   = r_en && (m_cnt == 0) && !m_pend;
      b_ready = r_rdy;
      b_clr   = 1'b0;

      checkOutput("rnd_valid", b_valid, m_valid);
      if (cyc % 100 == 0) checkOutput("rnd_cnt", b_cnt, LB'(m_cnt));
      if (m_valid && r_rdy) popCompare("rnd_desc", b_desc);

      m_loaded = 1'b0;
      if (m_pend) begin
        if (r_en) m_ovf = 1'b1;
        if (m_valid && r_rdy) m_pend = 1'b0;
      end else begin
        if (r_en) begin
          m_acc[m_cnt] = r_data;
          if (m_cnt == LB - 1) begin
            exp_q.push_back(m_acc);
            m_cnt = 0;
            if (!m_valid || r_rdy) m_loaded = 1'b1;
            else m_pend = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        if (m_loaded) m_valid = 1'b1;
        else if (m_valid && r_rdy) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("rnd_overflow", b_ovf, m_ovf);
    checkOutput("rnd_sync", b_serr, 0);
    checkOutput("rnd_drained", LB'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
